// File: rtl/ldp_ext_pkg.sv
// Shared EXT_BUS command codes and the streamer state encoding.
package ldp_ext_pkg;

    localparam logic [15:0] CD_GET   = 16'h0034;
    localparam logic [15:0] CD_SET   = 16'h0035;
    localparam logic [15:0] CMD_STAT = 16'h0037;
    localparam logic [15:0] CMD_DATA = 16'h0038;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ldp_state_t;

endpackage

// File: rtl/ldp_word_fifo.sv
// Synchronous 16-bit word FIFO with flush and occupancy; read data is registered on pop.
module ldp_word_fifo #(
    parameter int AW = 12
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [15:0]   din,
    input  logic          pop,
    output logic [15:0]   dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    logic [15:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge sys_clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) dout <= '0;
        else if (do_pop) dout <= mem[rd_ptr];
    end

endmodule

// File: rtl/ldp_sector_streamer.sv
// HPS sector fetch over EXT_BUS command frames and byte feed to the MPEG-2 decoder.
module ldp_sector_streamer
    import ldp_ext_pkg::ldp_state_t;
    import ldp_ext_pkg::IDLE;
    import ldp_ext_pkg::RUN;
#(
    parameter int          SECTOR_BYTES = 1024,
    parameter int          FIFO_AW      = 12,
    parameter logic [15:0] CMD_STAT     = ldp_ext_pkg::CMD_STAT,
    parameter logic [15:0] CMD_DATA     = ldp_ext_pkg::CMD_DATA
) (
    input  logic               sys_clk,
    input  logic               RESET_N,
    input  logic               io_enable,
    input  logic               io_strobe,
    input  logic [15:0]        io_din,
    output logic [15:0]        io_dout,
    output logic               dout_en,
    input  logic               start,
    input  logic [31:0]        start_lba,
    input  logic               stop,
    input  logic               stream_busy,
    output logic [7:0]         stream_data,
    output logic               stream_valid,
    output logic [FIFO_AW:0]   fifo_words,
    output logic               underrun,
    output logic               sector_err,
    output ldp_state_t         state_dbg
);

    localparam int             SECTOR_WORDS = SECTOR_BYTES / 2;
    localparam logic [9:0]     LAST_WORD    = 10'(SECTOR_WORDS + 2);
    localparam logic [9:0]     END_CNT      = 10'(SECTOR_WORDS + 3);
    localparam logic [FIFO_AW:0] ROOM_MAX   = (FIFO_AW+1)'((1 << FIFO_AW) - SECTOR_WORDS);

    ldp_state_t  state;
    ldp_state_t  state_nxt;

    logic        flush;
    logic        seek;
    logic [9:0]  byte_cnt;
    logic [15:0] cmd;
    logic [15:0] lba_lo;
    logic        stat_frame;
    logic        data_acc;
    logic        en_q;
    logic        wstrobe;
    logic        payload_w;
    logic        over_w;
    logic        last_push;
    logic        trunc;
    logic        req_pending;
    logic [31:0] req_lba;
    logic [31:0] next_lba;

    logic        fifo_pop;
    logic [15:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        ob_valid;
    logic [15:0] lat_word;
    logic [1:0]  lat_cnt;
    logic [1:0]  cnt_after;
    logic        load;

    // stop outranks start; either one flushes the datapath at the next edge
    assign flush     = start || stop;
    assign seek      = start && !stop;
    assign state_dbg = state;

    always_ff @(posedge sys_clk) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
    end

    assign wstrobe   = io_enable && io_strobe;
    assign payload_w = wstrobe && data_acc && (byte_cnt >= 10'd3) && (byte_cnt <= LAST_WORD) && !flush;
    assign over_w    = wstrobe && data_acc && (byte_cnt > LAST_WORD);
    assign last_push = payload_w && (byte_cnt == LAST_WORD);
    assign trunc     = !io_enable && en_q && data_acc && (byte_cnt != END_CNT);
    assign dout_en   = io_enable && (stat_frame || (wstrobe && byte_cnt == 10'd0 && io_din == CMD_STAT));

    always_ff @(posedge sys_clk) begin
        if (!RESET_N || !io_enable) begin
            byte_cnt   <= '0;
            cmd        <= '0;
            lba_lo     <= '0;
            stat_frame <= 1'b0;
        end else if (wstrobe) begin
            if (byte_cnt != 10'h3FF) byte_cnt <= byte_cnt + 10'd1;
            if (byte_cnt == 10'd0) begin
                cmd        <= io_din;
                stat_frame <= (io_din == CMD_STAT);
            end
            if (byte_cnt == 10'd1) lba_lo <= io_din;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!RESET_N) en_q <= 1'b0;
        else          en_q <= io_enable;
    end

    // A data frame is owned only while the request it answers is still live.
    always_ff @(posedge sys_clk) begin
        if (!RESET_N || !io_enable || flush) begin
            data_acc <= 1'b0;
        end else if (wstrobe && byte_cnt == 10'd2 && cmd == CMD_DATA && req_pending
                     && {io_din, lba_lo} == req_lba) begin
            data_acc <= 1'b1;
        end
    end

    // Response word k+1 is staged on the strobe of word k.
    always_ff @(posedge sys_clk) begin
        if (!RESET_N || !io_enable) begin
            io_dout <= '0;
        end else if (wstrobe) begin
            if (byte_cnt == 10'd0)
                io_dout <= (io_din == CMD_STAT) ? {15'b0, req_pending} : 16'h0000;
            else if (stat_frame && byte_cnt == 10'd1)
                io_dout <= req_lba[15:0];
            else if (stat_frame && byte_cnt == 10'd2)
                io_dout <= req_lba[31:16];
            else
                io_dout <= '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!RESET_N) begin
            req_pending <= 1'b0;
            req_lba     <= '0;
            next_lba    <= '0;
        end else if (stop) begin
            req_pending <= 1'b0;
        end else if (start) begin
            req_pending <= 1'b0;
            next_lba    <= start_lba;
        end else if (last_push) begin
            req_pending <= 1'b0;
            next_lba    <= next_lba + 32'd1;
        end else if (state == RUN && !req_pending && fifo_words <= ROOM_MAX) begin
            req_pending <= 1'b1;
            req_lba     <= next_lba;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!RESET_N || seek) begin
            underrun   <= 1'b0;
            sector_err <= 1'b0;
        end else if (!stop) begin
            if (trunc || over_w || (payload_w && fifo_full)) sector_err <= 1'b1;
            if (state == RUN && !stream_busy && lat_cnt == 2'd0) underrun <= 1'b1;
        end
    end

    ldp_word_fifo #(.AW(FIFO_AW)) u_fifo (
        .sys_clk (sys_clk),
        .reset_n (RESET_N),
        .flush   (flush),
        .push    (payload_w),
        .din     (io_din),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .count   (fifo_words),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Decoder handshake: stream_valid is high for exactly the cycles in which a
    // byte is delivered; it is only raised while stream_busy is low, and every
    // cycle with stream_valid high consumes stream_data. While busy the latch holds.
    assign stream_valid = !stream_busy && (lat_cnt != 2'd0);
    always_comb begin
        stream_data = 8'h00;
        if (lat_cnt == 2'd2)      stream_data = lat_word[7:0];
        else if (lat_cnt == 2'd1) stream_data = lat_word[15:8];
    end

    assign cnt_after = lat_cnt - {1'b0, stream_valid};
    assign load      = (cnt_after == 2'd0) && ob_valid;
    assign fifo_pop  = !fifo_empty && (!ob_valid || load) && !flush;

    // ob_valid marks an unconsumed word sitting in the FIFO read register.
    always_ff @(posedge sys_clk) begin
        if (!RESET_N) begin
            lat_word <= '0;
            lat_cnt  <= '0;
            ob_valid <= 1'b0;
        end else if (flush) begin
            lat_cnt  <= '0;
            ob_valid <= 1'b0;
        end else begin
            if (load) begin
                lat_word <= fifo_dout;
                lat_cnt  <= 2'd2;
            end else begin
                lat_cnt  <= cnt_after;
            end
            if (fifo_pop)  ob_valid <= 1'b1;
            else if (load) ob_valid <= 1'b0;
        end
    end

endmodule
